seg14_scan_sched: RTL and testbench
===================================

# seg14_scan_sched

Scan scheduler and message controller for the 12-digit, 14-segment multiplexed display. It holds a double-buffered 12-character message, decodes characters through the team's standard 14-segment glyph set, and time-multiplexes the digit selects at a programmable dwell rate. It sits between the host-side character writer and the display pads (`sel`/`segm`). It replaces the free-running hard-coded digit counter with a loadable, commit-synchronised, optionally scrolling sequencer.

## Interface
- `DIGITS`, 12: number of digit positions; width of `sel`.
- `DWELL`, 4: clock cycles each digit is held; must be ≥ 2.
- `SCROLL_FRAMES`, 2: number of complete frames per scroll step.

- `clk`  in  1  — single clock; all logic on its rising edge.
- `rst_n`  in  1  — reset; synchronous, active-low.
- `wr_valid`  in  1  — character write request.
- `wr_ready`  out  1  — write can be accepted this cycle.
- `wr_addr`  in  4  — shadow-buffer position, 0..DIGITS-1.
- `wr_char`  in  6  — character code:
  - 0–25 = A–Z
  - 26–35 = 0–9
  - 36–63 = blank
- `commit`  in  1  — request to copy the shadow buffer to the active buffer.
- `commit_pending`  out  1  — a commit is waiting for the frame boundary.
- `scroll_en`  in  1  — enables rotation of the displayed message.
- `sel`  out  DIGITS  — one-hot digit select.
- `segm`  out  14  — segment pattern for the selected digit.
- `frame_tick`  out  1  — one-cycle pulse at each frame boundary.

## Operation
- **Reset values** (while `rst_n`=0 at a clock edge):
  - `sel`=0, `segm`=0, `frame_tick`=0, `commit_pending`=0, `wr_ready`=1.
  - Both buffers filled with code 63 (blank).
  - Dwell counter=0, digit index=0, scroll offset=0, frame counter=0.
  - Reset mid-write or mid-commit aborts it; shadow contents are discarded.
- **Scan:**
  - The dwell counter counts 0..DWELL-1.
  - When it reaches DWELL-1, the digit index advances modulo DIGITS.
  - A frame boundary is the cycle in which the index wraps from DIGITS-1 to 0.
- **Output:**
  - `sel` = one-hot of the current digit index d.
  - `segm` = glyph(active[(d+offset) mod DIGITS]).
  - Both are registered.
- **Glyphs:** bit 13 is segment a, using the team's standard 14-segment set.
  - A=`11101111000000`, C=`10011100000000`, E=`10011110000000`
  - I=`10010000010010`, J=`01111000000000`, K=`00001110001100`
  - R=`11001111000100`, T=`10000000010010`
  - 0=`11111100001001`, 1=`01100000001000`
  - blank=all zeros
- **Write handshake:**
  - A write is accepted when `wr_valid`&&`wr_ready`; `wr_char` goes to shadow[`wr_addr`].
  - A write with `wr_addr` ≥ DIGITS is accepted and discarded.
  - Writes never alter the active buffer directly.
- **Commit:**
  - `commit` while `commit_pending`=0 sets `commit_pending`=1 and drops `wr_ready` to 0 on the next cycle.
  - `commit` while already pending is ignored.
  - At the next frame boundary: active ← shadow, offset ← 0, frame counter ← 0, `commit_pending` ← 0, `wr_ready` ← 1 (all in the same edge).
- **Simultaneous events:**
  - `wr_valid` and `commit` in the same cycle: the write is accepted and included in the commit.
  - If `commit` is asserted in the frame-boundary cycle itself, the copy waits for the following boundary.
- **Scroll:** see Configuration. The offset update and a commit on the same boundary resolve with the commit winning (offset=0).

## Timing
- Output latency is 1 cycle: `sel`/`segm` reflect the index and dwell state of the previous cycle.
- After `rst_n` rises:
  - First nonzero output is `sel`=`...0001` one cycle later.
  - Digit 0 is held DWELL cycles, then digit 1.
- `frame_tick` is high exactly one cycle, aligned with the first output cycle of digit 0 in each new frame. The full period is DIGITS×DWELL cycles.
- Committed data first appears on `segm` in the same output cycle as `frame_tick`.
- `wr_ready` is combinationally equal to !`commit_pending`.
- Worst-case commit-to-ready time is DIGITS×DWELL+1 cycles.

## Configuration
- Macro: `SEG14_SCROLL_EN`.
- **Defined:**
  - When `scroll_en`=1, the frame counter increments at each frame boundary.
  - On reaching SCROLL_FRAMES-1, it clears and the offset increments modulo DIGITS (11 wraps to 0).
  - When `scroll_en`=0, the offset and frame counter hold their values.
- **Not defined:**
  - The offset is constant 0 and the frame counter is absent.
  - `scroll_en` is present but ignored.

## Test plan
- **Reset and idle scan:** reset, then free-run 100 cycles.
  - `sel` steps `...001`, `...010`, … every 4 cycles.
  - `segm`=0 throughout.
  - `frame_tick` period is 48.
- **Load and commit:** write "ERICK JA T" (E,R,I,C,K,blank,J,A,blank,T,blank,blank) to addresses 0–11, then assert `commit`.
  - `wr_ready`=0 until the boundary.
  - From `frame_tick` onward, digit 0 shows `segm`=`10011110000000` and digit 1 shows `11001111000100`.
- **Write during pending:** hold `wr_valid` with addr 0, code 0 while pending.
  - No acceptance occurs.
  - After the boundary, the write is accepted.
  - Digit 0 still shows E until the next commit.
- **Simultaneous:** assert write (addr 3, code 0) and `commit` in the same cycle → digit 3 shows A=`11101111000000` after the boundary.
- **Out-of-range:** write addr 12 or 15 → accepted, no buffer change.
- **Scroll (macro on, `scroll_en`=1):**
  - After 2 frames, digit 0 shows R.
  - After 24 frames, the offset wraps to 0 and digit 0 shows E.
  - A reset mid-frame clears outputs on the next edge.

Source files
------------

// File: rtl/seg14_scan_sched.sv
// Scan scheduler for a 12-digit 14-segment display: double-buffered message,
// commit synchronised to the frame boundary. Define SEG14_SCROLL_EN for scrolling.
module seg14_scan_sched #(
    parameter int DIGITS        = 12,
    parameter int DWELL         = 4,
    parameter int SCROLL_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_addr,
    input  logic [5:0]        wr_char,
    input  logic              commit,
    output logic              commit_pending,
    input  logic              scroll_en,
    output logic [DIGITS-1:0] sel,
    output logic [13:0]       segm,
    output logic              frame_tick
);

    localparam int            IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int            DW         = $clog2(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);
    localparam logic [IW:0]   DIGITS_P   = (IW + 1)'(DIGITS);
    localparam logic [4:0]    DIGITS_W   = 5'(DIGITS);
    localparam logic [5:0]    BLANK      = 6'd63;

    logic [DW-1:0] dwell;
    logic [IW-1:0] idx;
    logic [IW-1:0] offset;
    logic [5:0]    shadow [DIGITS];
    logic [5:0]    active [DIGITS];
    logic          tick_q;

    logic          dwell_last;
    logic          boundary;
    logic          commit_now;
    logic          wr_fire;
    logic [IW:0]   pos_sum;
    logic [IW-1:0] pos;

    function automatic logic [13:0] glyph(input logic [5:0] code);
        logic [13:0] g;
        // bit order a b c d e f g1 g2 h i j k l m
        case (code)
            6'd0:    g = 14'b11101111000000;
            6'd1:    g = 14'b11110001010010;
            6'd2:    g = 14'b10011100000000;
            6'd3:    g = 14'b11110000010010;
            6'd4:    g = 14'b10011110000000;
            6'd5:    g = 14'b10001110000000;
            6'd6:    g = 14'b10111101000000;
            6'd7:    g = 14'b01101111000000;
            6'd8:    g = 14'b10010000010010;
            6'd9:    g = 14'b01111000000000;
            6'd10:   g = 14'b00001110001100;
            6'd11:   g = 14'b00011100000000;
            6'd12:   g = 14'b01101100101000;
            6'd13:   g = 14'b01101100100100;
            6'd14:   g = 14'b11111100000000;
            6'd15:   g = 14'b11001111000000;
            6'd16:   g = 14'b11111100000100;
            6'd17:   g = 14'b11001111000100;
            6'd18:   g = 14'b10110111000000;
            6'd19:   g = 14'b10000000010010;
            6'd20:   g = 14'b01111100000000;
            6'd21:   g = 14'b00001100001001;
            6'd22:   g = 14'b01101100000101;
            6'd23:   g = 14'b00000000101101;
            6'd24:   g = 14'b00000000101010;
            6'd25:   g = 14'b10010000001001;
            6'd26:   g = 14'b11111100001001;
            6'd27:   g = 14'b01100000001000;
            6'd28:   g = 14'b11011011000000;
            6'd29:   g = 14'b11110001000000;
            6'd30:   g = 14'b01100111000000;
            6'd31:   g = 14'b10110111000000;
            6'd32:   g = 14'b10111111000000;
            6'd33:   g = 14'b11100000000000;
            6'd34:   g = 14'b11111111000000;
            6'd35:   g = 14'b11110111000000;
            default: g = '0;
        endcase
        return g;
    endfunction

    always_comb begin
        dwell_last = (dwell == DWELL_LAST);
        boundary   = dwell_last && (idx == DIGIT_LAST);
        commit_now = boundary && commit_pending;
        wr_fire    = wr_valid && wr_ready && ({1'b0, wr_addr} < DIGITS_W);
        pos_sum    = {1'b0, idx} + {1'b0, offset};
        pos        = (pos_sum >= DIGITS_P) ? IW'(pos_sum - DIGITS_P) : pos_sum[IW-1:0];
    end

    assign wr_ready = !commit_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell          <= '0;
            idx            <= '0;
            sel            <= '0;
            segm           <= '0;
            tick_q         <= 1'b0;
            frame_tick     <= 1'b0;
            commit_pending <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                shadow[i] <= BLANK;
                active[i] <= BLANK;
            end
        end else begin
            sel  <= DIGITS'(1) << idx;
            segm <= glyph(active[pos]);

            // frame_tick lines up with the first output cycle of digit 0, one edge after the wrap
            tick_q     <= boundary;
            frame_tick <= tick_q;

            if (dwell_last) begin
                dwell <= '0;
                idx   <= (idx == DIGIT_LAST) ? '0 : idx + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end

            if (wr_fire) begin
                shadow[wr_addr[IW-1:0]] <= wr_char;
            end

            if (commit_now) begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
                commit_pending <= 1'b0;
            end else if (commit && !commit_pending) begin
                commit_pending <= 1'b1;
            end
        end
    end

`ifdef SEG14_SCROLL_EN
    localparam int            FW         = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_FRAMES - 1);

    logic [FW-1:0] frame_cnt;

    // a commit on the same boundary overrides the scroll step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset    <= '0;
            frame_cnt <= '0;
        end else if (commit_now) begin
            offset    <= '0;
            frame_cnt <= '0;
        end else if (boundary && scroll_en) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                offset    <= (offset == DIGIT_LAST) ? '0 : offset + 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_scroll;

    assign offset        = '0;
    assign unused_scroll = scroll_en;
`endif

endmodule

// File: tb/tb_seg14_scan_sched.sv
// Bench for seg14_scan_sched: time-based reference model plus directed
// scenarios (idle scan, load/commit, pending writes, scroll, reset).
module tb_seg14_scan_sched;

    localparam int DIGITS = 12;
    localparam int DWELL  = 4;
    localparam int SF     = 2;
    localparam int FRAME  = DIGITS * DWELL;

    localparam logic [13:0] G_A = 14'b11101111000000;
    localparam logic [13:0] G_E = 14'b10011110000000;
    localparam logic [13:0] G_R = 14'b11001111000100;
    localparam logic [13:0] G_T = 14'b10000000010010;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [3:0]        wr_addr;
    logic [5:0]        wr_char;
    logic              commit;
    logic              commit_pending;
    logic              scroll_en;
    logic [DIGITS-1:0] sel;
    logic [13:0]       segm;
    logic              frame_tick;

    always #5 clk = ~clk;

    seg14_scan_sched #(
        .DIGITS        (DIGITS),
        .DWELL         (DWELL),
        .SCROLL_FRAMES (SF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_char        (wr_char),
        .commit         (commit),
        .commit_pending (commit_pending),
        .scroll_en      (scroll_en),
        .sel            (sel),
        .segm           (segm),
        .frame_tick     (frame_tick)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // only the glyphs the message set uses
    function automatic logic [13:0] glyph_ref(input logic [5:0] c);
        if (c >= 6'd36) return '0;
        case (c)
            6'd0:    return G_A;
            6'd2:    return 14'b10011100000000;
            6'd4:    return G_E;
            6'd8:    return 14'b10010000010010;
            6'd9:    return 14'b01111000000000;
            6'd10:   return 14'b00001110001100;
            6'd17:   return G_R;
            6'd19:   return G_T;
            6'd26:   return 14'b11111100001001;
            6'd27:   return 14'b01100000001000;
            default: return 'x;
        endcase
    endfunction

    // Reference model: scan position p counts edges since reset release.
    int                p;
    logic [5:0]        m_sh  [DIGITS];
    logic [5:0]        m_act [DIGITS];
    int                m_off;
    int                m_fr;
    bit                m_pend;
    bit                exp_valid = 0;
    logic [DIGITS-1:0] exp_sel;
    logic [13:0]       exp_segm;
    logic              exp_tick;
    logic              exp_ready;
    int                last_tick = -1;
    int                cyc = 0;

    always @(posedge clk) begin
        int  d;
        bit  bnd;
        exp_valid = 1;
        if (!rst_n) begin
            p      = 0;
            m_off  = 0;
            m_fr   = 0;
            m_pend = 0;
            for (int i = 0; i < DIGITS; i++) begin
                m_sh[i]  = 6'd63;
                m_act[i] = 6'd63;
            end
            exp_sel   = '0;
            exp_segm  = '0;
            exp_tick  = 1'b0;
            exp_ready = 1'b1;
            last_tick = -1;
        end else begin
            d          = (p / DWELL) % DIGITS;
            exp_sel    = '0;
            exp_sel[d] = 1'b1;
            exp_segm   = glyph_ref(m_act[(d + m_off) % DIGITS]);
            exp_tick   = (p > 0) && (p % FRAME == 0);
            bnd        = ((p + 1) % FRAME == 0);
            if (wr_valid && !m_pend && int'(wr_addr) < DIGITS)
                m_sh[wr_addr] = wr_char;
            if (bnd && m_pend) begin
                for (int i = 0; i < DIGITS; i++) m_act[i] = m_sh[i];
                m_off  = 0;
                m_fr   = 0;
                m_pend = 0;
            end else begin
                if (commit && !m_pend) m_pend = 1;
`ifdef SEG14_SCROLL_EN
                if (bnd && scroll_en) begin
                    if (m_fr == SF - 1) begin
                        m_fr  = 0;
                        m_off = (m_off + 1) % DIGITS;
                    end else begin
                        m_fr++;
                    end
                end
`endif
            end
            exp_ready = !m_pend;
            p++;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (exp_valid) begin
            check("sel", 32'(sel), 32'(exp_sel));
            check("segm", 32'(segm), 32'(exp_segm));
            check("frame_tick", 32'(frame_tick), 32'(exp_tick));
            check("wr_ready", 32'(wr_ready), 32'(exp_ready));
            check("commit_pending", 32'(commit_pending), 32'(!exp_ready));
            if (frame_tick === 1'b1) begin
                if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'd48);
                last_tick = cyc;
            end
        end
    end

    task automatic wait_tick();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_tick actual=timeout required=frame_tick at %0t", $time);
        end
    endtask

    logic [5:0] msg [DIGITS] = '{6'd4, 6'd17, 6'd8, 6'd2, 6'd10, 6'd63,
                                 6'd9, 6'd0, 6'd63, 6'd19, 6'd63, 6'd63};

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_char   = '0;
        commit    = 1'b0;
        scroll_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sel", 32'(sel), 32'h0);
        check("reset_ready", 32'(wr_ready), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_sel", 32'(sel), 32'h001);
        check("first_segm", 32'(segm), 32'h0);
        repeat (100) @(negedge clk);

        // load message and commit
        wait_tick();
        for (int i = 0; i < DIGITS; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 4'(i);
            wr_char  = msg[i];
            @(negedge clk);
        end
        wr_valid = 1'b0;
        commit   = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check("pending_set", 32'(commit_pending), 32'h1);
        check("ready_drop", 32'(wr_ready), 32'h0);
        wait_tick();
        check("commit_d0_sel", 32'(sel), 32'h001);
        check("commit_d0_E", 32'(segm), 32'(G_E));
        check("commit_ready", 32'(wr_ready), 32'h1);
        repeat (4) @(negedge clk);
        check("commit_d1_sel", 32'(sel), 32'h002);
        check("commit_d1_R", 32'(segm), 32'(G_R));

        // scroll (ignored when the feature is compiled out)
        scroll_en = 1'b1;
        wait_tick();
        wait_tick();
        check("scroll2_sel", 32'(sel), 32'h001);
`ifdef SEG14_SCROLL_EN
        check("scroll2_R", 32'(segm), 32'(G_R));
        repeat (22) wait_tick();
        check("scroll24_E", 32'(segm), 32'(G_E));
`else
        check("noscroll_E", 32'(segm), 32'(G_E));
`endif
        scroll_en = 1'b0;

        // write held while pending is not accepted until after the boundary
        commit = 1'b1;
        @(negedge clk);
        commit   = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 4'd0;
        wr_char  = 6'd0;
        check("pend_ready", 32'(wr_ready), 32'h0);
        wait_tick();
        wr_valid = 1'b0;
        check("pend_d0_E", 32'(segm), 32'(G_E));
        wait_tick();
        check("pend_d0_stillE", 32'(segm), 32'(G_E));

        // write and commit in the same cycle
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_char  = 6'd0;
        commit   = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b0;
        wait_tick();
        check("simul_d0_A", 32'(segm), 32'(G_A));
        repeat (12) @(negedge clk);
        check("simul_d3_sel", 32'(sel), 32'h008);
        check("simul_d3_A", 32'(segm), 32'(G_A));

        // out-of-range addresses are accepted and dropped
        wr_valid = 1'b1;
        wr_addr  = 4'd12;
        wr_char  = 6'd19;
        @(negedge clk);
        check("oor_ready", 32'(wr_ready), 32'h1);
        wr_addr = 4'd15;
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        wait_tick();
        check("oor_d0_A", 32'(segm), 32'(G_A));
        repeat (36) @(negedge clk);
        check("oor_d9_sel", 32'(sel), 32'h200);
        check("oor_d9_T", 32'(segm), 32'(G_T));
        repeat (12) @(negedge clk);

        // reset mid-frame aborts a pending commit and blanks both buffers
        repeat (5) @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check("rst_pend_before", 32'(commit_pending), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_segm", 32'(segm), 32'h0);
        check("rst_tick", 32'(frame_tick), 32'h0);
        check("rst_pend", 32'(commit_pending), 32'h0);
        check("rst_ready", 32'(wr_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerun_sel", 32'(sel), 32'h001);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        wait_tick();
        check("rerun_d0_blank", 32'(segm), 32'h0);
        repeat (FRAME) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
